// File: rtl/cnn_dense_argmax.sv
// Dense classifier output stage: streamed features, saturating MACs
// into per-class accumulators, then a sequential strict-greater argmax.
module cnn_dense_argmax #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_FEATURES = 16,
  parameter int NUM_CLASSES  = 10,
  parameter int ACC_WIDTH    = 20,
  localparam int CW = $clog2(NUM_CLASSES),
  localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         w_we,
  input  logic [CW-1:0]                w_class,
  input  logic [FW-1:0]                w_feat,
  input  logic signed [DATA_WIDTH-1:0] w_data,
  output logic                         w_busy,
  output logic [NUM_CLASSES-1:0]       out,
  output logic [CW-1:0]                out_idx,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = ACC_WIDTH;

  localparam logic signed [AW-1:0] ACC_MAX =
    {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN =
    {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM,
    ARGMAX,
    DONE
  } state_t;

  state_t state;

  logic [FW-1:0] count;
  logic [CW-1:0] cmp_i;
  logic [CW-1:0] best_idx;
  logic signed [AW-1:0] best_val;

  logic signed [AW-1:0] acc [NUM_CLASSES];
  logic signed [AW-1:0] acc_nxt [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0]
    wt [NUM_CLASSES][NUM_FEATURES];

  logic accept;
  logic w_ok;
  logic last_feat;
  logic last_cmp;
  logic take;
  logic signed [AW-1:0] run_val;
  logic signed [AW-1:0] cand_val;
  logic signed [AW-1:0] win_val;
  logic [CW-1:0] run_idx;
  logic [CW-1:0] win_idx;

  // Full-precision product, sign-extended, clamped on overflow.
  function automatic logic signed [AW-1:0] mac(
    input logic signed [AW-1:0]         a,
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] w
  );
    logic signed [PW-1:0] p;
    logic signed [AW:0]   ax;
    logic signed [AW:0]   px;
    logic signed [AW:0]   s;
    p  = $signed({{DATA_WIDTH{x[DATA_WIDTH-1]}}, x})
       * $signed({{DATA_WIDTH{w[DATA_WIDTH-1]}}, w});
    ax = {a[AW-1], a};
    px = {{(AW+1-PW){p[PW-1]}}, p};
    s  = ax + px;
    if (s[AW] != s[AW-1])
      return s[AW] ? ACC_MIN : ACC_MAX;
    return s[AW-1:0];
  endfunction

  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid & in_ready;
  assign w_busy    = (state == ARGMAX)
                   | ((state == ACCUM) & (count != '0));
  assign w_ok      = w_we & ~w_busy
                   & (int'(w_class) < NUM_CLASSES)
                   & (int'(w_feat) < NUM_FEATURES);
  assign last_feat = (int'(count) == NUM_FEATURES - 1);
  assign last_cmp  = (int'(cmp_i) == NUM_CLASSES - 1);

  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++)
      acc_nxt[c] = mac(acc[c], in_data, wt[c][count]);
  end

  // Class 0 seeds the running best on the first compare.
  always_comb begin
    run_val  = best_val;
    run_idx  = best_idx;
    if (cmp_i == CW'(1)) begin
      run_val = acc[0];
      run_idx = '0;
    end
    cand_val = acc[cmp_i];
    take     = cand_val > run_val;
    win_val  = take ? cand_val : run_val;
    win_idx  = take ? cmp_i : run_idx;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= ACCUM;
      count     <= '0;
      cmp_i     <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      out       <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc[c] <= '0;
        for (int f = 0; f < NUM_FEATURES; f++)
          wt[c][f] <= '0;
      end
    end else begin
      if (w_ok)
        wt[w_class][w_feat] <= w_data;
      unique case (state)
        ACCUM: begin
          if (accept) begin
            for (int c = 0; c < NUM_CLASSES; c++)
              acc[c] <= acc_nxt[c];
            if (last_feat) begin
              count <= '0;
              cmp_i <= CW'(1);
              state <= ARGMAX;
            end else begin
              count <= count + FW'(1);
            end
          end
        end
        ARGMAX: begin
          best_val <= win_val;
          best_idx <= win_idx;
          cmp_i    <= cmp_i + CW'(1);
          if (last_cmp) begin
            out       <= NUM_CLASSES'(1) << win_idx;
            out_idx   <= win_idx;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out       <= '0;
            for (int c = 0; c < NUM_CLASSES; c++)
              acc[c] <= '0;
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_dense_argmax.sv
// Bench for cnn_dense_argmax: default instance plus a 16-bit
// accumulator instance sharing stimulus, checked against a model.
module tb_cnn_dense_argmax;

  localparam int NF = 16;
  localparam int NC = 10;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic in_valid = 1'b0;
  logic signed [7:0] in_data = '0;
  logic w_we = 1'b0;
  logic [3:0] w_class = '0;
  logic [3:0] w_feat = '0;
  logic signed [7:0] w_data = '0;
  logic out_ready = 1'b0;

  logic in_ready_a, w_busy_a, out_valid_a;
  logic [NC-1:0] out_a;
  logic [3:0] out_idx_a;
  logic in_ready_b, w_busy_b, out_valid_b;
  logic [NC-1:0] out_b;
  logic [3:0] out_idx_b;

  always #5 clk = ~clk;

  cnn_dense_argmax dut (
    .clk(clk), .rst_(rst_),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data),
    .w_we(w_we), .w_class(w_class), .w_feat(w_feat),
    .w_data(w_data), .w_busy(w_busy_a),
    .out(out_a), .out_idx(out_idx_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  cnn_dense_argmax #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_(rst_),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data),
    .w_we(w_we), .w_class(w_class), .w_feat(w_feat),
    .w_data(w_data), .w_busy(w_busy_b),
    .out(out_b), .out_idx(out_idx_b),
    .out_valid(out_valid_b), .out_ready(out_ready)
  );

  int passed = 0;
  int total = 0;
  int wt [NC][NF];
  int last_exp, last_exp16;
  int pw_c, pw_f, pw_d;
  int aw_c, aw_f, aw_d;

  typedef struct packed {
    int c0; int f0; int d0;
    int c1; int f1; int d1;
    int fa; int fb; int fill;
    int exp;
  } vec_t;

  vec_t tbl [5];
  vec_t v;
  int feats [NF];

  task automatic chk(input string name, input longint act,
                     input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  // Dot products with clamp after every add, then first maximum.
  function automatic int model_idx(input int f[NF], input int aw);
    longint one, hi, lo;
    longint acc [NC];
    int best;
    one = 1;
    hi = (one << (aw - 1)) - 1;
    lo = -(one << (aw - 1));
    for (int c = 0; c < NC; c++) begin
      acc[c] = 0;
      for (int k = 0; k < NF; k++) begin
        acc[c] += longint'(f[k]) * longint'(wt[c][k]);
        if (acc[c] > hi) acc[c] = hi;
        if (acc[c] < lo) acc[c] = lo;
      end
    end
    best = 0;
    for (int c = 1; c < NC; c++)
      if (acc[c] > acc[best]) best = c;
    return best;
  endfunction

  task automatic write_w(input int c, input int f, input int d);
    @(negedge clk);
    chk("idle_w_busy", w_busy_a, 0);
    w_we = 1'b1;
    w_class = 4'(c);
    w_feat = 4'(f);
    w_data = 8'(d);
    @(posedge clk);
    #1 w_we = 1'b0;
    wt[c][f] = d;
  endtask

  task automatic run_frame(input int f[NF], input int wr_at,
                           input bit argwr);
    int lat;
    last_exp = model_idx(f, 20);
    last_exp16 = model_idx(f, 16);
    for (int i = 0; i < NF; i++) begin
      @(negedge clk);
      chk("in_ready_accum", in_ready_a, 1);
      in_valid = 1'b1;
      in_data = 8'(f[i]);
      w_we = 1'b0;
      if (i == wr_at) begin
        chk("frame_w_busy", w_busy_a, (i != 0) ? 1 : 0);
        w_we = 1'b1;
        w_class = 4'(pw_c);
        w_feat = 4'(pw_f);
        w_data = 8'(pw_d);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    w_we = 1'b0;
    if (wr_at == 0) wt[pw_c][pw_f] = pw_d;
    chk("in_ready_argmax", in_ready_a, 0);
    lat = 0;
    while (!out_valid_a && lat < 40) begin
      w_we = 1'b0;
      if (lat == 0 && argwr) begin
        chk("argmax_w_busy", w_busy_a, 1);
        w_we = 1'b1;
        w_class = 4'(aw_c);
        w_feat = 4'(aw_f);
        w_data = 8'(aw_d);
      end
      lat++;
      @(negedge clk);
    end
    w_we = 1'b0;
    chk("latency", lat, NC - 1);
    chk("out_valid16", out_valid_b, 1);
    chk("out_idx", out_idx_a, last_exp);
    chk("out_onehot", out_a, longint'(1) << last_exp);
    chk("out_idx16", out_idx_b, last_exp16);
    chk("out_onehot16", out_b, longint'(1) << last_exp16);
  endtask

  task automatic finish_frame(input int hold, input bit dw);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", out_valid_a, 1);
      chk("hold_idx", out_idx_a, last_exp);
      chk("hold_out", out_a, longint'(1) << last_exp);
      chk("hold_in_ready", in_ready_a, 0);
    end
    if (dw) begin
      chk("done_w_busy", w_busy_a, 0);
      w_we = 1'b1;
      w_class = 4'(pw_c);
      w_feat = 4'(pw_f);
      w_data = 8'(pw_d);
      @(negedge clk);
      w_we = 1'b0;
      wt[pw_c][pw_f] = pw_d;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", out_valid_a, 0);
    chk("post_out", out_a, 0);
    chk("post_in_ready", in_ready_a, 1);
    chk("post_valid16", out_valid_b, 0);
  endtask

  task automatic fill_feats(input int a, input int b,
                            input int rest);
    for (int k = 0; k < NF; k++) feats[k] = rest;
    feats[0] = a;
    feats[1] = b;
  endtask

  initial begin
    tbl[0] = '{0, 0, 0,   0, 0, 0,   7, 7, 7,   0};
    tbl[1] = '{3, 0, 2,   5, 1, 1,   5, 9, 0,   3};
    tbl[2] = '{5, 1, 2,   3, 0, 2,   5, 9, 0,   5};
    tbl[3] = '{9, 2, -1,  0, 0, 0,  -3, 0, 0,   0};
    tbl[4] = '{8, 15, 3,  9, 2, -1,  0, 0, -2,  9};

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out", out_a, 0);
    rst_ = 1'b1;
    @(negedge clk);
    chk("rst_out_idx", out_idx_a, 0);
    chk("rst_w_busy", w_busy_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_in_ready16", in_ready_b, 1);

    for (int r = 0; r < 5; r++) begin
      v = tbl[r];
      write_w(v.c0, v.f0, v.d0);
      write_w(v.c1, v.f1, v.d1);
      fill_feats(v.fa, v.fb, v.fill);
      run_frame(feats, -1, 1'b0);
      chk("tbl_idx", out_idx_a, v.exp);
      finish_frame(0, 1'b0);
    end

    // Saturation in both directions on the 16-bit instance.
    write_w(3, 0, 0);
    write_w(5, 1, 0);
    write_w(9, 2, 0);
    write_w(8, 15, 0);
    for (int k = 0; k < NF; k++) write_w(7, k, -128);
    fill_feats(-128, -128, -128);
    run_frame(feats, -1, 1'b0);
    chk("sat_pos_idx16", out_idx_b, 7);
    finish_frame(0, 1'b0);
    for (int k = 0; k < NF; k++) write_w(7, k, 127);
    run_frame(feats, -1, 1'b0);
    chk("sat_neg_idx16", out_idx_b, 0);
    finish_frame(0, 1'b0);

    // Backpressure with a weight write while the result is held.
    fill_feats(1, 0, 0);
    run_frame(feats, -1, 1'b0);
    chk("bp_idx", out_idx_a, 7);
    pw_c = 2; pw_f = 0; pw_d = 127;
    finish_frame(5, 1'b1);
    fill_feats(4, 0, 0);
    run_frame(feats, -1, 1'b0);
    chk("bp_new_weight_idx", out_idx_a, 2);
    finish_frame(0, 1'b0);

    // Writes mid-frame and during argmax must be dropped.
    pw_c = 2; pw_f = 0; pw_d = -128;
    aw_c = 0; aw_f = 0; aw_d = 127;
    run_frame(feats, 4, 1'b1);
    chk("busy_idx", out_idx_a, 2);
    finish_frame(0, 1'b0);
    run_frame(feats, -1, 1'b0);
    chk("busy_after_idx", out_idx_a, 2);
    finish_frame(0, 1'b0);

    // Write at count 0 alongside feature 0 lands after the MAC.
    pw_c = 0; pw_f = 0; pw_d = 127;
    run_frame(feats, 0, 1'b0);
    chk("same_edge_idx", out_idx_a, 2);
    finish_frame(0, 1'b0);
    run_frame(feats, -1, 1'b0);
    chk("same_edge_next_idx", out_idx_a, 0);
    finish_frame(0, 1'b0);

    // Reset mid-frame wipes weights and the partial frame.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid_a, 0);
    chk("midrst_out", out_a, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_ = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready_a, 1);
    chk("midrst_w_busy", w_busy_a, 0);
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NF; k++) wt[c][k] = 0;
    for (int k = 0; k < NF; k++)
      feats[k] = int'($urandom_range(0, 255)) - 128;
    run_frame(feats, -1, 1'b0);
    chk("midrst_idx", out_idx_a, 0);
    finish_frame(0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      for (int j = 0; j < 12; j++)
        write_w($urandom_range(0, NC - 1), $urandom_range(0, NF - 1),
                int'($urandom_range(0, 255)) - 128);
      for (int k = 0; k < NF; k++)
        feats[k] = int'($urandom_range(0, 255)) - 128;
      run_frame(feats, -1, 1'b0);
      finish_frame($urandom_range(0, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
